// File: rtl/spi_agc_ctrl.sv
// SPI master for two AGC channels: 16-bit mode-0 frame {command, data}, two chip selects.
// Read-back path is built only when SPI_AGC_READBACK_EN is defined.
module spi_agc_ctrl #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       main_clk,
  input  logic       main_rst_n,
  input  logic       start,
  input  logic       channel,
  input  logic [7:0] spi_mode,
  input  logic [7:0] spi_dataA,
  input  logic [7:0] spi_dataB,
  output logic [7:0] read_data,
  output logic       busy,
  output logic       done,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic [1:0] spi_cs_n
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_e;

  localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

  state_e      state_q, state_d;
  logic        start_q;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  bit_q, bit_d;
  logic        sclk_q, sclk_d;
  logic [1:0]  cs_q, cs_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] shreg_q, shreg_d;
  logic        start_edge;

`ifdef SPI_AGC_READBACK_EN
  logic        rd_q, rd_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  rdata_q, rdata_d;
`else
  logic        unused_miso;
  assign unused_miso = spi_miso;
`endif

  assign start_edge = start & ~start_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sclk_d  = sclk_q;
    cs_d    = cs_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    shreg_d = shreg_q;
`ifdef SPI_AGC_READBACK_EN
    rd_d    = rd_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d = SETUP;
          cnt_d   = RELOAD;
          busy_d  = 1'b1;
          cs_d    = channel ? 2'b01 : 2'b10;
          shreg_d = {spi_mode, spi_mode[0] ? 8'h00 : (channel ? spi_dataB : spi_dataA)};
`ifdef SPI_AGC_READBACK_EN
          rd_d    = spi_mode[0];
`endif
        end
      end
      SETUP: begin
        if (cnt_q == 8'd0) begin
          state_d = SHIFT;
          cnt_d   = RELOAD;
          bit_d   = 4'd15;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      SHIFT: begin
        if (cnt_q == 8'd0) begin
          cnt_d = RELOAD;
          if (!sclk_q) begin
            sclk_d = 1'b1;
`ifdef SPI_AGC_READBACK_EN
            rx_d   = {rx_q[6:0], spi_miso};
`endif
          end else begin
            sclk_d = 1'b0;
            // MOSI is the shift register MSB, so it only moves when a new low phase starts
            if (bit_q == 4'd0) begin
              state_d = HOLD;
            end else begin
              bit_d   = bit_q - 4'd1;
              shreg_d = {shreg_q[14:0], 1'b0};
            end
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      HOLD: begin
        if (cnt_q == 8'd0) begin
          state_d = GAP;
          cnt_d   = RELOAD;
          cs_d    = 2'b11;
          done_d  = 1'b1;
          shreg_d = '0;
`ifdef SPI_AGC_READBACK_EN
          if (rd_q) rdata_d = rx_q;
`endif
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      GAP: begin
        if (cnt_q == 8'd0) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge main_clk or negedge main_rst_n) begin
    if (!main_rst_n) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      cnt_q   <= '0;
      bit_q   <= '0;
      sclk_q  <= 1'b0;
      cs_q    <= '1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      shreg_q <= '0;
`ifdef SPI_AGC_READBACK_EN
      rd_q    <= 1'b0;
      rx_q    <= '0;
      rdata_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      start_q <= start;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sclk_q  <= sclk_d;
      cs_q    <= cs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      shreg_q <= shreg_d;
`ifdef SPI_AGC_READBACK_EN
      rd_q    <= rd_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
`endif
    end
  end

  assign spi_sclk = sclk_q;
  assign spi_mosi = shreg_q[15];
  assign spi_cs_n = cs_q;
  assign busy     = busy_q;
  assign done     = done_q;
`ifdef SPI_AGC_READBACK_EN
  assign read_data = rdata_q;
`else
  assign read_data = 8'h00;
`endif

endmodule

// File: tb/tb_spi_agc_ctrl.sv
// Bench for spi_agc_ctrl: CLK_DIV=4 and CLK_DIV=1 instances, slave model and frame scoreboard.
module tb_spi_agc_ctrl;

  typedef struct {
    logic [1:0]  cs;
    logic [15:0] frame;
    logic [7:0]  rd;
    int          done_at;
    int          busy;
    int          per;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start0, start1;
  logic        ch;
  logic [7:0]  mode, dA, dB, slave;
  logic        miso;
  logic [15:0] tx;

  logic [7:0]  rd_w   [2];
  logic        busy_w [2];
  logic        done_w [2];
  logic        sclk_w [2];
  logic        mosi_w [2];
  logic [1:0]  cs_w   [2];

  exp_t        sb0[$], sb1[$];
  exp_t        me;
  logic [7:0]  model_rd;

  int          total = 0, passed = 0, fails = 0;
  int          cyc = 0;
  int          busy_cnt[2], exp_busy[2], done_cnt[2], nb[2], per[2], last_rise[2];
  logic        pend[2], prev_sclk[2], prev_busy[2];
  logic [1:0]  prev_cs[2], cap_cs[2];
  logic [15:0] cap[2];

  always #5 clk = ~clk;

  spi_agc_ctrl #(.CLK_DIV(4)) u_div4 (
    .main_clk(clk), .main_rst_n(rst_n), .start(start0), .channel(ch),
    .spi_mode(mode), .spi_dataA(dA), .spi_dataB(dB), .read_data(rd_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .spi_sclk(sclk_w[0]), .spi_mosi(mosi_w[0]),
    .spi_miso(miso), .spi_cs_n(cs_w[0])
  );

  spi_agc_ctrl #(.CLK_DIV(1)) u_div1 (
    .main_clk(clk), .main_rst_n(rst_n), .start(start1), .channel(ch),
    .spi_mode(mode), .spi_dataA(dA), .spi_dataB(dB), .read_data(rd_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .spi_sclk(sclk_w[1]), .spi_mosi(mosi_w[1]),
    .spi_miso(1'b0), .spi_cs_n(cs_w[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sets the bus inputs and queues the frame the slave should see.
  task automatic expect_txn(input int k, input logic c, input logic [7:0] m,
                            input logic [7:0] a, input logic [7:0] b, input logic [7:0] s);
    exp_t e;
    int   div;
    div = (k == 0) ? 4 : 1;
    ch = c; mode = m; dA = a; dB = b; slave = s;
    e.cs    = c ? 2'b01 : 2'b10;
    e.frame = {m, m[0] ? 8'h00 : (c ? b : a)};
`ifdef SPI_AGC_READBACK_EN
    e.rd = (k == 0) ? (m[0] ? s : model_rd) : 8'h00;
`else
    e.rd = 8'h00;
`endif
    if (k == 0) model_rd = e.rd;
    e.done_at = 34 * div;
    e.busy    = 35 * div;
    e.per     = 2 * div;
    if (k == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endtask

  task automatic wait_idle(input int k);
    int n;
    n = 0;
    @(negedge clk);
    while (busy_w[k] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      total++;
      fails++;
      $error("FAIL busy_timeout dut%0d: observed busy=1 expected busy=0", k);
    end
    repeat (2) @(negedge clk);
  endtask

  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        busy_cnt[k] = 0; pend[k] = 1'b0; prev_sclk[k] = 1'b0;
        prev_cs[k] = 2'b11; prev_busy[k] = 1'b0;
      end else begin
        if (prev_cs[k] == 2'b11 && cs_w[k] != 2'b11) begin
          cap_cs[k] = cs_w[k]; cap[k] = '0; nb[k] = 0;
          if (k == 0) begin tx = {8'hC3, slave}; miso = tx[15]; end
        end
        if (sclk_w[k] && !prev_sclk[k]) begin
          cap[k] = {cap[k][14:0], mosi_w[k]};
          nb[k]++;
          per[k] = cyc - last_rise[k];
          last_rise[k] = cyc;
        end
        if (!sclk_w[k] && prev_sclk[k] && k == 0) begin
          tx = {tx[14:0], 1'b0};
          miso = tx[15];
        end
        if (done_w[k]) begin
          done_cnt[k]++;
          if ((k == 0) ? (sb0.size() == 0) : (sb1.size() == 0)) begin
            total++;
            fails++;
            $error("FAIL unexpected_done dut%0d: observed done=1 expected no transaction", k);
          end else begin
            me = (k == 0) ? sb0.pop_front() : sb1.pop_front();
            chk("frame_cs",  32'(cap_cs[k]), 32'(me.cs));
            chk("mosi_frame", 32'(cap[k]),   32'(me.frame));
            chk("sclk_rises", 32'(nb[k]),    32'd16);
            chk("read_data", 32'(rd_w[k]),   32'(me.rd));
            chk("done_time", 32'(busy_cnt[k]), 32'(me.done_at));
            chk("sclk_period", 32'(per[k]),  32'(me.per));
            chk("cs_release", 32'(cs_w[k]),  32'd3);
            exp_busy[k] = me.busy;
            pend[k] = 1'b1;
          end
        end
        if (busy_w[k]) busy_cnt[k]++;
        else begin
          if (prev_busy[k] && pend[k]) chk("busy_len", 32'(busy_cnt[k]), 32'(exp_busy[k]));
          pend[k] = 1'b0;
          busy_cnt[k] = 0;
        end
        prev_cs[k] = cs_w[k]; prev_sclk[k] = sclk_w[k]; prev_busy[k] = busy_w[k];
      end
    end
  end

  initial begin
    int dc;
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; ch = 1'b0;
    mode = '0; dA = '0; dB = '0; slave = '0; miso = 1'b0; model_rd = '0;
    tx = '0;
    for (int k = 0; k < 2; k++) begin
      done_cnt[k] = 0; last_rise[k] = 0; nb[k] = 0; per[k] = 0; cap[k] = '0; cap_cs[k] = 2'b11;
    end
    repeat (3) @(negedge clk);
    chk("rst_cs",   32'(cs_w[0]),   32'd3);
    chk("rst_sclk", 32'(sclk_w[0]), 32'd0);
    chk("rst_mosi", 32'(mosi_w[0]), 32'd0);
    chk("rst_busy", 32'(busy_w[0]), 32'd0);
    chk("rst_done", 32'(done_w[0]), 32'd0);
    chk("rst_rdata", 32'(rd_w[0]),  32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // write, channel A
    expect_txn(0, 1'b0, 8'h24, 8'hF3, 8'h11, 8'h00);
    start0 = 1'b1;
    @(negedge clk);
    chk("first_busy", 32'(busy_w[0]), 32'd1);
    chk("first_cs",   32'(cs_w[0]),   32'd2);
    chk("first_mosi", 32'(mosi_w[0]), 32'd0);
    chk("first_sclk", 32'(sclk_w[0]), 32'd0);
    start0 = 1'b0;
    wait_idle(0);
    chk("idle_mosi", 32'(mosi_w[0]), 32'd0);

    // read, channel B
    expect_txn(0, 1'b1, 8'hAB, 8'h77, 8'h66, 8'h5A);
    start0 = 1'b1;
    @(negedge clk);
    chk("rd_first_cs",   32'(cs_w[0]),   32'd1);
    chk("rd_first_mosi", 32'(mosi_w[0]), 32'd1);
    start0 = 1'b0;
    wait_idle(0);

    // retrigger and bus changes mid-frame are ignored
    dc = done_cnt[0];
    expect_txn(0, 1'b0, 8'h42, 8'h99, 8'h10, 8'h00);
    start0 = 1'b1;
    repeat (5) @(negedge clk);
    start0 = 1'b0;
    repeat (15) @(negedge clk);
    dA = 8'h00; mode = 8'hFF; ch = 1'b1;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_idle(0);
    repeat (150) @(negedge clk);
    chk("one_done_retrig", 32'(done_cnt[0] - dc), 32'd1);

    // reset during bit 7 aborts the frame
    dc = done_cnt[0];
    ch = 1'b1; mode = 8'h81; dB = 8'h7E;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (68) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_cs",   32'(cs_w[0]),   32'd3);
    chk("abort_sclk", 32'(sclk_w[0]), 32'd0);
    chk("abort_busy", 32'(busy_w[0]), 32'd0);
    chk("abort_mosi", 32'(mosi_w[0]), 32'd0);
    model_rd = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (150) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt[0] - dc), 32'd0);
    chk("abort_rdata",   32'(rd_w[0]),          32'd0);

    // clean frame after the abort
    expect_txn(0, 1'b0, 8'h33, 8'h00, 8'h00, 8'hA5);
    mode = 8'h33;
    expect_txn(0, 1'b0, 8'h35, 8'hC0, 8'h00, 8'hA5);
    void'(sb0.pop_back());
    sb0.pop_back();
    model_rd = 8'h00;
    expect_txn(0, 1'b0, 8'h33, 8'hC0, 8'h00, 8'hA5);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_idle(0);

    // start held high across two frame lengths
    dc = done_cnt[0];
    expect_txn(0, 1'b1, 8'h10, 8'h00, 8'hC8, 8'h00);
    start0 = 1'b1;
    repeat (300) @(negedge clk);
    chk("held_one_done", 32'(done_cnt[0] - dc), 32'd1);
    chk("held_idle",     32'(busy_w[0]),        32'd0);
    start0 = 1'b0;
    repeat (2) @(negedge clk);

    // start already high when reset releases: exactly one frame
    rst_n = 1'b0;
    model_rd = 8'h00;
    @(negedge clk);
    dc = done_cnt[0];
    expect_txn(0, 1'b0, 8'h02, 8'h5C, 8'h00, 8'h00);
    start0 = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    chk("rel_one_done", 32'(done_cnt[0] - dc), 32'd1);
    start0 = 1'b0;
    repeat (2) @(negedge clk);

    // CLK_DIV=1 instance
    dc = done_cnt[1];
    expect_txn(1, 1'b0, 8'hC5, 8'h3C, 8'h00, 8'h00);
    start1 = 1'b1;
    @(negedge clk);
    chk("d1_first_mosi", 32'(mosi_w[1]), 32'd1);
    start1 = 1'b0;
    wait_idle(1);
    chk("d1_one_done", 32'(done_cnt[1] - dc), 32'd1);
    chk("sb0_empty", 32'(sb0.size()), 32'd0);
    chk("sb1_empty", 32'(sb1.size()), 32'd0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
